// File: rtl/if_id_register_pkg.sv
// Shared MIPS pipeline constants: bubble encoding and instruction field layout.
// Imported by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package if_id_register_pkg;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int REG_W   = 5;
    localparam int FN_LSB  = 0;
    localparam int FN_W    = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register_if.sv
// IF/ID bundle: fetch-side inputs, hazard controls and decoded fields.
interface if_id_register_if #(parameter int DATA_W = 32);

    logic [DATA_W-1:0] Instruction_in;
    logic [DATA_W-1:0] PCPlus4_in;
    logic              Valid_in;
    logic              Stall;
    logic              Flush;

    logic [DATA_W-1:0] Instruction_out;
    logic [DATA_W-1:0] PCPlus4_out;
    logic              Valid_out;
    logic [5:0]        Opcode;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [4:0]        Shamt;
    logic [5:0]        Funct;
    logic [15:0]       Imm16;
    logic [25:0]       Target26;
    logic [15:0]       StallCycles;

    modport master (
        output Instruction_in, PCPlus4_in, Valid_in, Stall, Flush,
        input  Instruction_out, PCPlus4_out, Valid_out,
        input  Opcode, Rs, Rt, Rd, Shamt, Funct, Imm16, Target26,
        input  StallCycles
    );

    modport slave (
        input  Instruction_in, PCPlus4_in, Valid_in, Stall, Flush,
        output Instruction_out, PCPlus4_out, Valid_out,
        output Opcode, Rs, Rt, Rd, Shamt, Funct, Imm16, Target26,
        output StallCycles
    );

endinterface

// File: rtl/if_id_register_pipe_reg.sv
// Generic pipeline register: async reset, sync clear-to-value, load enable.
module pipe_reg #(
    parameter int         W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] clr_val_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clear wins over enable so a squash lands even while held.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = clr_val_i;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with flush/stall control, field split and stall counter.
module if_id_register
    import if_id_register_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(if_id_register_pkg::NOP_WORD)
) (
    input logic           Clk,
    input logic           Rst,
    if_id_register_if.slave bus
);

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] instr_d;
    logic [DATA_W-1:0] pc4_q;
    logic              valid_q;
    logic              load_en;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign load_en = ~bus.Stall;
    // A non-valid fetch is squashed to a bubble at the input.
    assign instr_d = bus.Valid_in ? bus.Instruction_in : NOP_WORD;

    pipe_reg #(.W(DATA_W), .RST_VAL(NOP_WORD)) u_instr (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .en_i      (load_en),
        .clr_i     (bus.Flush),
        .clr_val_i (NOP_WORD),
        .d_i       (instr_d),
        .q_o       (instr_q)
    );

    pipe_reg #(.W(DATA_W), .RST_VAL('0)) u_pc4 (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .en_i      (load_en),
        .clr_i     (bus.Flush),
        .clr_val_i ('0),
        .d_i       (bus.PCPlus4_in),
        .q_o       (pc4_q)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .en_i      (load_en),
        .clr_i     (bus.Flush),
        .clr_val_i (1'b0),
        .d_i       (bus.Valid_in),
        .q_o       (valid_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!bus.Flush && bus.Stall && valid_q && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Instruction_out = instr_q;
    assign bus.PCPlus4_out     = pc4_q;
    assign bus.Valid_out       = valid_q;
    assign bus.Opcode          = instr_q[OPC_LSB +: OPC_W];
    assign bus.Rs              = instr_q[RS_LSB +: REG_W];
    assign bus.Rt              = instr_q[RT_LSB +: REG_W];
    assign bus.Rd              = instr_q[RD_LSB +: REG_W];
    assign bus.Shamt           = instr_q[SH_LSB +: REG_W];
    assign bus.Funct           = instr_q[FN_LSB +: FN_W];
    assign bus.Imm16           = instr_q[IMM_W-1:0];
    assign bus.Target26        = instr_q[TGT_W-1:0];
    assign bus.StallCycles     = stall_cnt_q;

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for the IF/ID register: reset, load, stall, flush, bubble, saturation.
module tb_if_id_register;

    logic Clk;
    logic Rst;
    int   vectors;
    int   errs;

    if_id_register_if #(.DATA_W(32)) bus();

    if_id_register #(.DATA_W(32), .NOP_WORD(32'h0000_0000)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic v, input logic st, input logic fl);
        bus.Instruction_in = ins;
        bus.PCPlus4_in     = pc;
        bus.Valid_in       = v;
        bus.Stall          = st;
        bus.Flush          = fl;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        Rst     = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_instr", bus.Instruction_out, 32'h0);
        chk("rst_pc", bus.PCPlus4_out, 32'h0);
        chk("rst_valid", {31'b0, bus.Valid_out}, 32'h0);
        chk("rst_cnt", {16'b0, bus.StallCycles}, 32'h0);

        @(negedge Clk);
        Rst = 1'b1;

        drive(32'h2128_FFFC, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
        step();
        chk("ld_instr", bus.Instruction_out, 32'h2128_FFFC);
        chk("ld_opcode", {26'b0, bus.Opcode}, 32'h08);
        chk("ld_rs", {27'b0, bus.Rs}, 32'd9);
        chk("ld_rt", {27'b0, bus.Rt}, 32'd8);
        chk("ld_rd", {27'b0, bus.Rd}, 32'd31);
        chk("ld_shamt", {27'b0, bus.Shamt}, 32'd31);
        chk("ld_funct", {26'b0, bus.Funct}, 32'h3C);
        chk("ld_imm16", {16'b0, bus.Imm16}, 32'h0000_FFFC);
        chk("ld_tgt26", {6'b0, bus.Target26}, 32'h0128_FFFC);
        chk("ld_pc", bus.PCPlus4_out, 32'h0000_0104);
        chk("ld_valid", {31'b0, bus.Valid_out}, 32'h1);
        chk("ld_cnt", {16'b0, bus.StallCycles}, 32'h0);

        drive(32'h8D09_0004, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
        step();
        chk("lw_instr", bus.Instruction_out, 32'h8D09_0004);
        drive(32'hDEAD_BEEF, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", bus.Instruction_out, 32'h8D09_0004);
        end
        chk("stall_pc", bus.PCPlus4_out, 32'h0000_0108);
        chk("stall_valid", {31'b0, bus.Valid_out}, 32'h1);
        chk("stall_cnt3", {16'b0, bus.StallCycles}, 32'd3);

        drive(32'hDEAD_BEEF, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        step();
        chk("fl_instr", bus.Instruction_out, 32'h0);
        chk("fl_valid", {31'b0, bus.Valid_out}, 32'h0);
        chk("fl_pc", bus.PCPlus4_out, 32'h0);
        chk("fl_cnt", {16'b0, bus.StallCycles}, 32'd3);

        drive(32'hDEAD_BEEF, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        step();
        step();
        chk("bub_stall_cnt", {16'b0, bus.StallCycles}, 32'd3);
        chk("bub_stall_valid", {31'b0, bus.Valid_out}, 32'h0);

        drive(32'hFFFF_FFFF, 32'h0000_010C, 1'b0, 1'b0, 1'b0);
        step();
        chk("bub_instr", bus.Instruction_out, 32'h0);
        chk("bub_valid", {31'b0, bus.Valid_out}, 32'h0);
        chk("bub_pc", bus.PCPlus4_out, 32'h0000_010C);
        chk("bub_cnt", {16'b0, bus.StallCycles}, 32'd3);

        drive(32'h012A_4020, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
        step();
        chk("add_instr", bus.Instruction_out, 32'h012A_4020);
        chk("ld_cnt_keep", {16'b0, bus.StallCycles}, 32'd3);
        drive(32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        step();
        drive(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        chk("bub2_cnt", {16'b0, bus.StallCycles}, 32'd3);

        drive(32'h012A_4020, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h1111_2222, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        chk("pre_rst_cnt", {16'b0, bus.StallCycles}, 32'd4);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_instr", bus.Instruction_out, 32'h0);
        chk("async_valid", {31'b0, bus.Valid_out}, 32'h0);
        chk("async_pc", bus.PCPlus4_out, 32'h0);
        chk("async_cnt", {16'b0, bus.StallCycles}, 32'h0);
        @(negedge Clk);
        drive(32'h3C01_1234, 32'h0000_0120, 1'b1, 1'b0, 1'b0);
        Rst = 1'b1;
        step();
        chk("post_rst_instr", bus.Instruction_out, 32'h3C01_1234);
        chk("post_rst_pc", bus.PCPlus4_out, 32'h0000_0120);

        drive(32'hCAFE_F00D, 32'h0000_0999, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            @(posedge Clk);
        end
        #1;
        chk("sat_pre", {16'b0, bus.StallCycles}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("sat_cnt", {16'b0, bus.StallCycles}, 32'h0000_FFFF);
        chk("long_hold_instr", bus.Instruction_out, 32'h3C01_1234);
        chk("long_hold_pc", bus.PCPlus4_out, 32'h0000_0120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/if_id_register.md
IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction and PC word width.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, SHALL be the instruction value inserted on flush and on reset.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Instruction_in  input  32  SHALL be the fetched instruction word from the IF stage.
REQ-006 PCPlus4_in  input  32  SHALL be the PC+4 of the fetched instruction.
REQ-007 Valid_in  input  1  SHALL mark Instruction_in as a real instruction.
REQ-008 Stall  input  1  SHALL be the hazard-unit hold request, active-high.
REQ-009 Flush  input  1  SHALL be the branch/jump squash request, active-high.
REQ-010 Instruction_out  output  32  SHALL be the registered instruction.
REQ-011 PCPlus4_out  output  32  SHALL be the registered PC+4.
REQ-012 Valid_out  output  1  SHALL be the registered valid flag.
REQ-013 Opcode[5:0], Rs[4:0], Rt[4:0], Rd[4:0], Shamt[4:0], Funct[5:0]  outputs SHALL be bit fields [31:26], [25:21], [20:16], [15:11], [10:6], [5:0] of Instruction_out.
REQ-014 Imm16  output  16  SHALL be Instruction_out[15:0], driving the decode-stage sign-extension input.
REQ-015 Target26  output  26  SHALL be Instruction_out[25:0].
REQ-016 StallCycles  output  16  SHALL be the saturating count of stalled cycles holding a valid instruction.

Function
REQ-017 Priority each edge SHALL be: Flush, then Stall, then load.
REQ-018 Flush=1: Instruction_out SHALL become NOP_WORD, Valid_out 0, PCPlus4_out 0, regardless of Stall.
REQ-019 Flush=0, Stall=1: Instruction_out, PCPlus4_out, Valid_out SHALL hold their values.
REQ-020 Flush=0, Stall=0: registers SHALL load Instruction_in, PCPlus4_in, Valid_in; latency exactly one cycle.
REQ-021 Valid_in=0 on load: Instruction_out SHALL load NOP_WORD, not Instruction_in.
REQ-022 Field outputs (REQ-013..015) SHALL be purely combinational from Instruction_out, with no added latency.
REQ-023 StallCycles SHALL increment by 1 on each edge with Stall=1, Flush=0, Valid_out=1.
REQ-024 StallCycles SHALL saturate at 16'hFFFF and never wrap.
REQ-025 StallCycles SHALL NOT change on flush, on load, or when stalling a bubble (Valid_out=0).
REQ-026 Back-to-back stalls of any length SHALL keep the held instruction bit-exact.

Reset
REQ-027 Rst=0 SHALL immediately, without waiting for Clk, force Instruction_out=NOP_WORD, PCPlus4_out=0, Valid_out=0, StallCycles=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after release SHALL follow REQ-017..021.

Structure
REQ-029 NOP_WORD and field bit-position constants SHALL live in the shared MIPS pipeline package, reused by ID/EX, EX/MEM and MEM/WB.
REQ-030 A single sub-module PipeReg (width-parameterised; enable, synchronous clear-to-value, async active-low reset) SHALL be instantiated for the instruction, PC and valid registers.

Verification
REQ-031 Reset: Rst=0 between edges -> all outputs zero/NOP at once; StallCycles=0.
REQ-032 Load: Instruction_in=32'h2128_FFFC, Valid_in=1 -> next cycle Opcode=6'h08, Rs=9, Rt=8, Imm16=16'hFFFC.
REQ-033 Stall: load 32'h8D09_0004, then Stall=1 for 3 cycles -> output held; StallCycles=3.
REQ-034 Flush with Stall on the same edge -> Instruction_out=0, Valid_out=0; StallCycles unchanged.
REQ-035 Saturation: preload the counter to 16'hFFFE, stall 3 valid cycles -> StallCycles=16'hFFFF.
REQ-036 Bubble: Valid_in=0 with Instruction_in=32'hFFFF_FFFF -> Instruction_out=NOP_WORD, Valid_out=0.
